// File: rtl/run_controller.sv
// run_controller: sequences the datapath through start/run/halt and streams the end-of-run register dump
module run_controller #(
  parameter int XLEN       = 64,
  parameter int NREGS      = 32,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      instruction_word,
  input  logic [XLEN-1:0]  pc_current,
  output logic             core_en,
  output logic             core_reset,
  output logic [4:0]       dbg_rd_addr,
  input  logic [XLEN-1:0]  dbg_rd_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [XLEN-1:0]  dump_data,
  output logic             dump_last,
  output logic [CNT_W-1:0] cycle_count,
  output logic [XLEN-1:0]  halt_pc,
  output logic             busy,
  output logic             timeout
);
  localparam int KW = $clog2(NREGS + 1);
  typedef enum logic [2:0] {IDLE, PRIME, RUN, DUMP, DONE} state_t;
  state_t            state_q;
  logic              en_q, crst_q, valid_q, last_q, tmo_q;
  logic [KW-1:0]     idx_q;
  logic [XLEN-1:0]   data_q, hpc_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              halt, wdog, load, fin;
  assign core_en     = en_q;
  assign core_reset  = crst_q;
  assign dbg_rd_addr = 5'(idx_q);
  assign dump_valid  = valid_q;
  assign dump_data   = data_q;
  assign dump_last   = last_q;
  assign cycle_count = cnt_q;
  assign halt_pc     = hpc_q;
  assign timeout     = tmo_q;
  assign busy        = state_q != IDLE && state_q != DONE;
  // saturating count, halt/watchdog detection and dump beat load/finish conditions
  always_comb begin
    cnt_d = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
    halt  = instruction_word == 32'h0;
    wdog  = MAX_CYCLES != 0 && cnt_d == CNT_W'(MAX_CYCLES);
    load  = state_q == DUMP && (!valid_q || (dump_ready && !last_q));
    fin   = valid_q && dump_ready && last_q;
  end
  // run sequencer; idx_q addresses the register whose data is loaded into the next beat
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      crst_q  <= 1'b1;
      idx_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      hpc_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= PRIME;
          crst_q  <= 1'b1;
          cnt_q   <= '0;
          tmo_q   <= 1'b0;
        end
        PRIME: begin
          state_q <= RUN;
          crst_q  <= 1'b0;
          en_q    <= 1'b1;
        end
        RUN: begin
          cnt_q <= cnt_d;
          if (halt || wdog) begin
            state_q <= DUMP;
            en_q    <= 1'b0;
            hpc_q   <= pc_current;
            tmo_q   <= !halt;
            idx_q   <= '0;
          end
        end
        DUMP: if (load) begin
          valid_q <= 1'b1;
          last_q  <= idx_q == KW'(NREGS);
          data_q  <= idx_q == KW'(NREGS) ? XLEN'(cnt_q) : dbg_rd_data;
          if (idx_q != KW'(NREGS)) idx_q <= idx_q + KW'(1);
        end else if (fin) begin
          valid_q <= 1'b0;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_run_controller.sv
// tb_run_controller: drives run_controller with a tiny ADDI/JAL datapath stub and checks dumps against a program model
module tb_run_controller;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, dump_ready = 1'b0;
  logic [31:0] instruction_word, cycle_count;
  logic [63:0] pc_current, dbg_rd_data, dump_data, halt_pc;
  logic        core_en, core_reset, dump_valid, dump_last, busy, timeout;
  logic [4:0]  dbg_rd_addr;
  logic [31:0] prog [64];
  logic [63:0] rf [32];
  int          n_cmp = 0, n_bad = 0;
  int          p_n;
  int          p_rd [16], p_rs1 [16];
  logic [11:0] p_imm [16];
  logic [63:0] beats [$];
  int          n_last, last_pos, unstable;
  bit          hung;

  always #5 clk = ~clk;

  run_controller #(.XLEN(64), .NREGS(32), .CNT_W(32), .MAX_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .instruction_word(instruction_word),
    .pc_current(pc_current), .core_en(core_en), .core_reset(core_reset),
    .dbg_rd_addr(dbg_rd_addr), .dbg_rd_data(dbg_rd_data), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_data(dump_data), .dump_last(dump_last),
    .cycle_count(cycle_count), .halt_pc(halt_pc), .busy(busy), .timeout(timeout)
  );

  assign instruction_word = prog[pc_current[7:2]];
  assign dbg_rd_data      = rf[dbg_rd_addr];

  always @(posedge clk) begin
    if (core_reset) begin
      pc_current <= '0;
      foreach (rf[i]) rf[i] <= '0;
    end else if (core_en) begin
      if (instruction_word[6:0] == 7'h13 && instruction_word[11:7] != 5'd0)
        rf[instruction_word[11:7]] <= rf[instruction_word[19:15]] + {{52{instruction_word[31]}}, instruction_word[31:20]};
      pc_current <= instruction_word[6:0] == 7'h6F
        ? pc_current + {{43{instruction_word[31]}}, instruction_word[31], instruction_word[19:12], instruction_word[20], instruction_word[30:21], 1'b0}
        : pc_current + 64'd4;
    end
  end

  function automatic logic [63:0] model_beat(input int k);
    logic [63:0] m [32];
    foreach (m[i]) m[i] = '0;
    for (int i = 0; i < p_n; i++) if (p_rd[i] != 0) m[p_rd[i]] = m[p_rs1[i]] + 64'($signed(p_imm[i]));
    return k == 32 ? 64'(p_n + 1) : m[k];
  endfunction

  task automatic load_prog();
    foreach (prog[i]) prog[i] = '0;
    for (int i = 0; i < p_n; i++) prog[i] = {p_imm[i], 5'(p_rs1[i]), 3'b000, 5'(p_rd[i]), 7'h13};
  endtask

  task automatic basic_prog();
    p_n = 2;
    p_rd[0] = 1; p_rs1[0] = 0; p_imm[0] = 12'd5;
    p_rd[1] = 2; p_rs1[1] = 1; p_imm[1] = 12'd3;
  endtask

  task automatic rand_prog(input int n);
    p_n = n;
    for (int i = 0; i < n; i++) begin
      p_rd[i]  = $urandom_range(0, 31);
      p_rs1[i] = $urandom_range(0, 31);
      p_imm[i] = 12'($urandom);
    end
  endtask

  task automatic run_dump(input int mode, input int start_at);
    logic [63:0] pd;
    logic        pl;
    logic [4:0]  pa;
    bit          stall, fin;
    beats.delete();
    n_last = 0; last_pos = -1; unstable = 0; stall = 0; fin = 0;
    start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 600 && !fin; i++) begin
      if (stall && (!dump_valid || dump_data !== pd || dump_last !== pl || dbg_rd_addr !== pa)) unstable++;
      start = (i == start_at);
      dump_ready = mode == 0 ? 1'b1 : mode == 1 ? (i % 4 == 0 || i % 4 == 3) : 1'($urandom_range(0, 1));
      stall = dump_valid && !dump_ready;
      pd = dump_data; pl = dump_last; pa = dbg_rd_addr;
      if (dump_valid && dump_ready) begin
        beats.push_back(dump_data);
        if (dump_last) begin
          n_last++;
          last_pos = beats.size() - 1;
          fin = 1;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    dump_ready = 1'b0;
    hung = !fin;
  endtask

  task automatic test_reset();
    n_cmp++; if (core_en !== 1'b0 || core_reset !== 1'b1) begin n_bad++; $display("FAIL reset_core: en=%b rst=%b want 0 1", core_en, core_reset); end
    n_cmp++; if (dump_valid !== 1'b0 || dump_last !== 1'b0 || dump_data !== 64'd0) begin n_bad++; $display("FAIL reset_dump: v=%b l=%b d=%h want 0 0 0", dump_valid, dump_last, dump_data); end
    n_cmp++; if (cycle_count !== 32'd0 || halt_pc !== 64'd0) begin n_bad++; $display("FAIL reset_cnt: cnt=%0d pc=%h want 0 0", cycle_count, halt_pc); end
    n_cmp++; if (busy !== 1'b0 || timeout !== 1'b0 || dbg_rd_addr !== 5'd0) begin n_bad++; $display("FAIL reset_misc: busy=%b tmo=%b addr=%0d want 0 0 0", busy, timeout, dbg_rd_addr); end
  endtask

  task automatic test_program(input string nm, input int mode, input int start_at);
    load_prog();
    run_dump(mode, start_at);
    n_cmp++; if (hung) begin n_bad++; $display("FAIL %s hang: no last beat within budget", nm); end
    n_cmp++; if (beats.size() != 33) begin n_bad++; $display("FAIL %s beats: got %0d want 33", nm, beats.size()); end
    n_cmp++; if (last_pos != 32 || n_last != 1) begin n_bad++; $display("FAIL %s last: pos %0d count %0d want 32 1", nm, last_pos, n_last); end
    for (int k = 0; k < beats.size() && k < 33; k++) begin
      n_cmp++; if (beats[k] !== model_beat(k)) begin n_bad++; $display("FAIL %s beat%0d: got %h want %h", nm, k, beats[k], model_beat(k)); end
    end
    n_cmp++; if (cycle_count !== 32'(p_n + 1)) begin n_bad++; $display("FAIL %s cycle_count: got %0d want %0d", nm, cycle_count, p_n + 1); end
    n_cmp++; if (halt_pc !== 64'(4 * p_n)) begin n_bad++; $display("FAIL %s halt_pc: got %h want %h", nm, halt_pc, 4 * p_n); end
    n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL %s timeout: got %b want 0", nm, timeout); end
    n_cmp++; if (unstable != 0) begin n_bad++; $display("FAIL %s stall_hold: %0d unstable stall cycles want 0", nm, unstable); end
    n_cmp++; if (busy !== 1'b0 || dump_valid !== 1'b0) begin n_bad++; $display("FAIL %s done: busy=%b valid=%b want 0 0", nm, busy, dump_valid); end
  endtask

  task automatic test_basic();
    basic_prog();
    test_program("basic", 0, -1);
  endtask

  task automatic test_stall();
    basic_prog();
    test_program("stall", 1, -1);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      rand_prog($urandom_range(1, 8));
      test_program("random", 2, -1);
    end
  endtask

  task automatic test_start_in_run();
    rand_prog(8);
    test_program("start_in_run", 0, 3);
  endtask

  task automatic test_priority();
    rand_prog(9);
    test_program("halt_priority", 0, -1);
  endtask

  task automatic test_timeout();
    foreach (prog[i]) prog[i] = '0;
    prog[0] = 32'h0000006F;
    run_dump(0, -1);
    n_cmp++; if (hung) begin n_bad++; $display("FAIL timeout hang: no last beat within budget"); end
    n_cmp++; if (beats.size() != 33) begin n_bad++; $display("FAIL timeout beats: got %0d want 33", beats.size()); end
    n_cmp++; if (timeout !== 1'b1) begin n_bad++; $display("FAIL timeout flag: got %b want 1", timeout); end
    n_cmp++; if (cycle_count !== 32'd10) begin n_bad++; $display("FAIL timeout cycle_count: got %0d want 10", cycle_count); end
    n_cmp++; if (halt_pc !== 64'd0) begin n_bad++; $display("FAIL timeout halt_pc: got %h want 0", halt_pc); end
    for (int k = 0; k < beats.size() && k < 33; k++) begin
      n_cmp++; if (beats[k] !== (k == 32 ? 64'd10 : 64'd0)) begin n_bad++; $display("FAIL timeout beat%0d: got %h want %h", k, beats[k], k == 32 ? 64'd10 : 64'd0); end
    end
  endtask

  task automatic test_reset_in_dump();
    int x = 0;
    bit got = 0;
    basic_prog();
    load_prog();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      dump_ready = 1'b1;
      if (dump_valid && x == 7) got = 1;
      else begin
        if (dump_valid) x++;
        @(posedge clk); #1;
      end
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL rst_dump reach: beat 7 not presented, got %0d transfers want 7", x); end
    reset = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (dump_valid !== 1'b0 || dump_last !== 1'b0) begin n_bad++; $display("FAIL rst_dump valid: v=%b l=%b want 0 0", dump_valid, dump_last); end
    n_cmp++; if (core_reset !== 1'b1 || core_en !== 1'b0) begin n_bad++; $display("FAIL rst_dump core: rst=%b en=%b want 1 0", core_reset, core_en); end
    n_cmp++; if (busy !== 1'b0 || cycle_count !== 32'd0) begin n_bad++; $display("FAIL rst_dump idle: busy=%b cnt=%0d want 0 0", busy, cycle_count); end
    reset = 1'b0;
    dump_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_dump wait: busy=%b want 0", busy); end
    test_program("rerun", 0, -1);
  endtask

  task automatic test_done_restart();
    basic_prog();
    test_program("done_restart", 0, -1);
  endtask

  initial begin
    foreach (prog[i]) prog[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_stall();
    test_random();
    test_start_in_run();
    test_timeout();
    test_priority();
    test_reset_in_dump();
    test_done_restart();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
